// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting and configurable frame format.
// Each received word carries parity/framing status into a show-ahead FIFO.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned PARITY          = 0,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned CLOCKS_PER_BAUD = 868,
  parameter int unsigned FIFO_AW         = 2,
  parameter int unsigned TIMER_BITS      = 16
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [FIFO_AW:0]     o_level,
  output logic                 o_overrun,
  input  logic                 i_clr_overrun,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned Half  = CLOCKS_PER_BAUD / 2;
  localparam int unsigned WordW = DATA_BITS + 2;

  localparam logic [TIMER_BITS-1:0] TimerMax = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [TIMER_BITS-1:0] TSampA   = TIMER_BITS'(Half + 1);
  localparam logic [TIMER_BITS-1:0] TSampB   = TIMER_BITS'(Half);
  localparam logic [TIMER_BITS-1:0] TSampC   = TIMER_BITS'(Half - 1);
  localparam logic [3:0]            LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]            LastStop = 4'(STOP_BITS - 1);
  localparam logic                  OddParity = (PARITY == 1);
  localparam logic [FIFO_AW:0]      LevelFull = (FIFO_AW + 1)'(Depth);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                  state_q;
  logic [2:0]              sync_q;
  logic                    rx_prev_q;
  logic [TIMER_BITS-1:0]   timer_q;
  logic [1:0]              samp_q;
  logic [3:0]              cnt_q;
  logic [DATA_BITS-1:0]    shift_q;
  logic                    pbit_q;
  logic                    perr_q;
  logic                    stop0_q;
  logic                    ferr_q;
  logic                    break_q;

  logic                    rx_s;
  logic                    decide;
  logic                    bit_val;
  logic                    push;
  logic                    first_stop;
  logic                    is_break;
  logic [WordW-1:0]        word;

  assign rx_s    = sync_q[2];
  assign decide  = (state_q != StIdle) && (timer_q == TSampC);
  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign push    = decide && (state_q == StStop) && (cnt_q == LastStop);

  // With one stop bit the first stop decision is the one being made right now.
  assign first_stop = (cnt_q == 4'd0) ? bit_val : stop0_q;
  assign is_break   = (shift_q == '0) && !pbit_q && !first_stop;
  assign word       = {shift_q, perr_q, ferr_q | ~bit_val};

  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      timer_q   <= '0;
      samp_q    <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      pbit_q    <= 1'b0;
      perr_q    <= 1'b0;
      stop0_q   <= 1'b0;
      ferr_q    <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], i_rx};
      rx_prev_q <= rx_s;
      break_q   <= push && is_break;
      if (state_q == StIdle) begin
        if (rx_prev_q && !rx_s) begin
          state_q <= StStart;
          timer_q <= TimerMax;
        end
      end else begin
        timer_q <= (timer_q == '0) ? TimerMax : timer_q - 1'b1;
        if (timer_q == TSampA) samp_q[0] <= rx_s;
        if (timer_q == TSampB) samp_q[1] <= rx_s;
        if (decide) begin
          unique case (state_q)
            StStart: begin
              if (bit_val) begin
                state_q <= StIdle;
              end else begin
                state_q <= StData;
                cnt_q   <= '0;
                ferr_q  <= 1'b0;
              end
            end
            StData: begin
              shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
              if (cnt_q == LastData) begin
                cnt_q   <= '0;
                state_q <= (PARITY != 0) ? StParity : StStop;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            StParity: begin
              pbit_q  <= bit_val;
              perr_q  <= (^shift_q) ^ bit_val ^ OddParity;
              state_q <= StStop;
            end
            StStop: begin
              if (cnt_q == 4'd0) stop0_q <= bit_val;
              ferr_q <= ferr_q | ~bit_val;
              if (cnt_q == LastStop) begin
                state_q <= StIdle;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign o_break = break_q;
  assign o_busy  = (state_q != StIdle);

  // Show-ahead FIFO
  logic [WordW-1:0]   mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               overrun_q;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               drop;

  assign full  = (level_q == LevelFull);
  assign pop   = (level_q != '0) && i_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop);
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (i_clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= word;
  end

  assign {o_data, o_parity_err, o_frame_err} = mem_q[rd_ptr_q];
  assign o_valid   = (level_q != '0);
  assign o_level   = level_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and a 7E1 instance, both at 16 clocks per bit,
// checked against a queue model of the words each transmitted frame must produce.
module tb_uart_rx_fifo;

  localparam int Cpb = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx_a, rx_b, ready_a, ready_b, clr_a, clr_b;

  logic [7:0] a_data;
  logic       a_pe, a_fe, a_valid, a_ovr, a_brk, a_busy;
  logic [2:0] a_level;
  logic [6:0] b_data;
  logic       b_pe, b_fe, b_valid, b_ovr, b_brk, b_busy;
  logic [2:0] b_level;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLOCKS_PER_BAUD(Cpb),
                 .FIFO_AW(2), .TIMER_BITS(8)) u_dut_a (
    .clk(clk), .i_reset(rst), .i_rx(rx_a), .o_data(a_data), .o_parity_err(a_pe),
    .o_frame_err(a_fe), .o_valid(a_valid), .i_ready(ready_a), .o_level(a_level),
    .o_overrun(a_ovr), .i_clr_overrun(clr_a), .o_break(a_brk), .o_busy(a_busy)
  );

  uart_rx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .CLOCKS_PER_BAUD(Cpb),
                 .FIFO_AW(2), .TIMER_BITS(8)) u_dut_b (
    .clk(clk), .i_reset(rst), .i_rx(rx_b), .o_data(b_data), .o_parity_err(b_pe),
    .o_frame_err(b_fe), .o_valid(b_valid), .i_ready(ready_b), .o_level(b_level),
    .o_overrun(b_ovr), .i_clr_overrun(clr_b), .o_break(b_brk), .o_busy(b_busy)
  );

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad = 0;
  int   vcnt_a = 0;
  int   brk_cnt = 0;
  int   exp_brk = 0;
  logic exp_ovr_a = 1'b0;
  logic [8:0] last_a, last_b;
  logic last_fe_a, last_pe_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Compare every popped word against the model, one cycle at a time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (a_valid && ready_a) begin
          if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_pop: got %0h want no word", a_data);
          end else begin
            e = qa.pop_front();
            check("a_data", 32'(a_data), 32'(e.d));
            check("a_perr", 32'(a_pe), 32'(e.pe));
            check("a_ferr", 32'(a_fe), 32'(e.fe));
            last_a    = 9'(a_data);
            last_fe_a = a_fe;
          end
        end
        if (b_valid && ready_b) begin
          if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_pop: got %0h want no word", b_data);
          end else begin
            e = qb.pop_front();
            check("b_data", 32'(b_data), 32'(e.d));
            check("b_perr", 32'(b_pe), 32'(e.pe));
            check("b_ferr", 32'(b_fe), 32'(e.fe));
            last_b    = 9'(b_data);
            last_pe_b = b_pe;
          end
        end
        if (a_valid) vcnt_a++;
        if (a_brk) brk_cnt++;
      end
    end
  end

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  // One bit time; a glitch inverts the line for the single clock at mid-bit.
  task automatic bit_time(input int sel, input logic v, input logic glitch);
    drive(sel, v);
    if (glitch) begin
      repeat (8) @(negedge clk);
      drive(sel, ~v);
      @(negedge clk);
      drive(sel, v);
      repeat (7) @(negedge clk);
    end else begin
      repeat (Cpb) @(negedge clk);
    end
  endtask

  task automatic model_push(input int sel, input exp_t e);
    if (sel == 0) begin
      if (qa.size() == 4) exp_ovr_a = 1'b1;
      else qa.push_back(e);
    end else begin
      qb.push_back(e);
    end
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input logic flip_par,
                            input logic stop_v, input int glitch_idx);
    int nb;
    logic [8:0] d;
    logic pb;
    exp_t e;
    nb = (sel == 0) ? 8 : 7;
    d  = data & ((9'd1 << nb) - 9'd1);
    pb = 1'b0;
    bit_time(sel, 1'b0, 1'b0);
    for (int i = 0; i < nb; i++) bit_time(sel, d[i], i == glitch_idx);
    if (sel == 1) begin
      pb = (^d) ^ flip_par;
      bit_time(sel, pb, 1'b0);
    end
    e.d  = d;
    e.pe = (sel == 1) ? (((^d) ^ pb) != 1'b0) : 1'b0;
    e.fe = ~stop_v;
    model_push(sel, e);
    bit_time(sel, stop_v, 1'b0);
    drive(sel, 1'b1);
  endtask

  task automatic quiet(input string tag);
    #1;
    check({tag, "_level_a"}, 32'(a_level), 32'(qa.size()));
    check({tag, "_valid_a"}, 32'(a_valid), 32'(qa.size() != 0));
    check({tag, "_ovr_a"}, 32'(a_ovr), 32'(exp_ovr_a));
    check({tag, "_brk"}, 32'(brk_cnt), 32'(exp_brk));
    check({tag, "_level_b"}, 32'(b_level), 32'(qb.size()));
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(a_valid), 0);
    check("rst_level", 32'(a_level), 0);
    check("rst_ovr", 32'(a_ovr), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_brk", 32'(a_brk), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: plain 8N1 word
    vcnt_a = 0;
    send_frame(0, 9'h41, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    quiet("t1");
    check("t1_valid_cycles", 32'(vcnt_a), 1);
    check("t1_lit_data", 32'(last_a), 32'h41);
    check("t1_lit_ferr", 32'(last_fe_a), 0);

    // 2: 7E1 with bad then good parity
    send_frame(1, 9'h35, 1'b1, 1'b1, -1);
    repeat (4) @(negedge clk);
    quiet("t2a");
    check("t2_lit_data", 32'(last_b), 32'h35);
    check("t2_lit_perr_bad", 32'(last_pe_b), 1);
    send_frame(1, 9'h35, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    quiet("t2b");
    check("t2_lit_perr_ok", 32'(last_pe_b), 0);

    // 3: false start, then mid-bit glitch
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("t3_busy_start", 32'(a_busy), 1);
    repeat (11) @(negedge clk);
    #1;
    check("t3_busy_idle", 32'(a_busy), 0);
    @(negedge clk);
    quiet("t3a");
    send_frame(0, 9'h4C, 1'b0, 1'b1, 1);
    repeat (4) @(negedge clk);
    quiet("t3b");
    check("t3_lit_glitch0", 32'(last_a), 32'h4C);
    send_frame(0, 9'h4C, 1'b0, 1'b1, 2);
    repeat (4) @(negedge clk);
    quiet("t3c");
    check("t3_lit_glitch1", 32'(last_a), 32'h4C);

    // 4: overrun with consumer stalled
    ready_a = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    quiet("t4_full");
    check("t4_lit_level", 32'(a_level), 4);
    ready_a = 1'b1;
    repeat (8) @(negedge clk);
    quiet("t4_drain");
    check("t4_lit_last", 32'(last_a), 32'h04);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    exp_ovr_a = 1'b0;
    quiet("t4_clr");

    // 5: framing error, then break
    send_frame(0, 9'h5A, 1'b0, 1'b0, -1);
    repeat (2 * Cpb) @(negedge clk);
    quiet("t5a");
    check("t5_lit_ferr", 32'(last_fe_a), 1);
    e.d = 9'h0; e.pe = 1'b0; e.fe = 1'b1;
    model_push(0, e);
    exp_brk = 1;
    rx_a = 1'b0;
    repeat (12 * Cpb) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * Cpb) @(negedge clk);
    quiet("t5b");
    check("t5_lit_brk_data", 32'(last_a), 0);

    // 6: reset mid-frame discards partial frame and FIFO contents
    ready_a = 1'b0;
    send_frame(0, 9'h3C, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    quiet("t6a");
    bit_time(0, 1'b0, 1'b0);
    bit_time(0, 1'b0, 1'b0);
    bit_time(0, 1'b1, 1'b0);
    bit_time(0, 1'b1, 1'b0);
    rx_a = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("t6_busy_pre", 32'(a_busy), 1);
    @(negedge clk);
    rst = 1'b1;
    rx_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    check("t6_busy_rst", 32'(a_busy), 0);
    check("t6_valid_rst", 32'(a_valid), 0);
    repeat (3 * Cpb) @(negedge clk);
    quiet("t6b");
    ready_a = 1'b1;
    send_frame(0, 9'hA5, 1'b0, 1'b1, -1);
    repeat (4) @(negedge clk);
    quiet("t6c");
    check("t6_lit_data", 32'(last_a), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Data bits, parity mode and stop-bit count are configurable. Each bit is decided by a 3-sample majority vote around mid-bit, and false starts are rejected. Received words carry per-word parity/framing status into a show-ahead FIFO with a valid/ready read port; overrun and break are flagged. Sits between the board RX pin and the command/loopback logic.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first on the line.
PARITY, 0, 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked, 1 or 2.
CLOCKS_PER_BAUD, 868, clk cycles per bit, >= 8 (868 = 115200 baud at 100 MHz).
FIFO_AW, 2, FIFO address bits; depth = 2**FIFO_AW.
TIMER_BITS, 16, bit-timer width, must hold CLOCKS_PER_BAUD-1.

Ports:
clk  in  1  clock.
i_reset  in  1  synchronous reset, active-high.
i_rx  in  1  asynchronous serial line, idle high.
o_data  out  DATA_BITS  head-of-FIFO data word.
o_parity_err  out  1  head word failed parity check (0 when PARITY=0).
o_frame_err  out  1  head word had a stop bit sampled low.
o_valid  out  1  FIFO non-empty.
i_ready  in  1  consumer accepts head word when o_valid && i_ready.
o_level  out  FIFO_AW+1  FIFO occupancy, 0..DEPTH.
o_overrun  out  1  sticky: a word was dropped because the FIFO was full.
i_clr_overrun  in  1  clears o_overrun.
o_break  out  1  one-cycle pulse: all data bits, parity and first stop bit sampled 0.
o_busy  out  1  receiver FSM not in IDLE.

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is clk. On reset: 3-flop synchroniser loads 1; FSM to IDLE; FIFO emptied; o_valid=0, o_level=0, o_overrun=0, o_break=0, o_busy=0. o_data, o_parity_err and o_frame_err are don't-care while o_valid=0. Reset mid-frame discards the partial frame.
- Sync: i_rx passes through 3 flops; rx_s = last stage. All logic uses rx_s only.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on rx_s falling edge (previous 1, current 0). The bit timer loads CLOCKS_PER_BAUD-1, decrements each cycle, and reloads to CLOCKS_PER_BAUD-1 at 0.
- Sampling: with H = CLOCKS_PER_BAUD/2, capture rx_s at timer values H+1, H and H-1. Bit value = majority of the three, decided at timer==H-1.
- START: decided value 1 -> IDLE (glitch rejected, nothing written); 0 -> DATA.
- DATA: DATA_BITS decisions, shifted LSB first; then go to PARITY if PARITY!=0, else STOP.
- PARITY: parity_err = (XOR of data ^ parity bit) != (PARITY==1 ? 1 : 0).
- STOP: STOP_BITS decisions; frame_err = any stop decision 0.
- At the last stop decision: push {data, parity_err, frame_err} and go to IDLE in the same cycle, so the next start edge may be detected from the following cycle. Back-to-back frames are supported.
- Break: data==0, parity bit (if any)==0 and first stop==0 -> o_break pulses 1 cycle at the push; the word is still pushed with frame_err=1.
- FIFO: show-ahead. A push into an empty FIFO gives o_valid=1 on the clock edge following the final stop decision. A pop occurs when o_valid && i_ready.
- FIFO boundaries:
  - Push while full with no pop: word dropped, o_overrun<=1, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no overrun.
  - Pop while empty: ignored.
  - Pointers wrap modulo DEPTH.
  - o_level is registered and exact.
- o_overrun: set has priority over i_clr_overrun in the same cycle.
- o_busy = FSM != IDLE.

Test Plan:
(Bench uses CLOCKS_PER_BAUD=16.)
1. Defaults 8N1, i_ready=1, send 0x41 -> one beat with o_data=0x41 and both error flags 0; o_valid high exactly 1 cycle; o_level returns 0.
2. PARITY=2, DATA_BITS=7, send 0x35 with the parity bit inverted -> o_data=0x35, o_parity_err=1; repeat with correct parity -> o_parity_err=0.
3. Hold i_rx low for 3 clks in IDLE -> no push, o_busy returns to 0 by mid-start; then a glitch of 1 clk inside a data bit at sample time -> bit value unaffected (majority).
4. i_ready=0, send DEPTH+1 frames 0x01..0x05 (DEPTH=4) -> o_level=4, o_overrun=1; drain yields 0x01..0x04; i_clr_overrun -> o_overrun=0.
5. Send a frame with stop bit 0 -> o_frame_err=1. Send a line held low for 12 bit-times -> o_break pulses once, word 0x00 with frame_err=1, no further push until i_rx returns high and falls again.
6. Assert i_reset at the 4th data bit -> o_busy=0 and o_valid=0 next cycle; a subsequent clean 0xA5 frame is received correctly.
